vibration_ctrl: RTL and testbench

Measurement sequencer for the 4-digit BCD vibration pulse counter. It synchronises and debounces the raw sensor line and clears the counter before each window. It gates count pulses into the counter for a fixed window, then latches the BCD result. It also flags overflow and threshold alarm, and runs single-shot or continuous.

---
 rtl/vibration_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_vibration_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vibration_ctrl.sv
// -----------------------------------------------------------------------------
// vibration_ctrl
// Measurement sequencer for an external 4-digit BCD vibration pulse counter.
// The raw sensor line is synchronised and debounced; each debounced rising
// edge inside the measurement window becomes one cnt_up pulse. The counter is
// cleared before each window and its BCD value is latched after the window,
// together with overflow and threshold-alarm flags.
//
// Ports:
//   clk_i            system clock, rising edge
//   rst_ni           asynchronous active-low reset
//   start_i          single-shot request (sampled in IDLE only)
//   cont_i           continuous mode level (windows repeat back-to-back)
//   sensor_i         raw asynchronous vibration sensor
//   count_in_i       BCD count from the external counter
//   thresh_i         BCD alarm threshold, 16'h0000 disables the alarm
//   cnt_rst_o        active-high clear to the counter
//   cnt_up_o         one-cycle count pulse to the counter
//   result_o         latched BCD result of the last window
//   result_valid_o   one-cycle pulse when result_o updates
//   overflow_o       last window exceeded 9999 events
//   alarm_o          last result >= thresh_i (thresh_i nonzero)
//   busy_o           high in every state except IDLE
// -----------------------------------------------------------------------------
module vibration_ctrl #(
  parameter int unsigned GATE_CYCLES = 50000000,
  parameter int unsigned DEB_CYCLES  = 500000,
  parameter int unsigned CLR_CYCLES  = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        cont_i,
  input  logic        sensor_i,
  input  logic [15:0] count_in_i,
  input  logic [15:0] thresh_i,
  output logic        cnt_rst_o,
  output logic        cnt_up_o,
  output logic [15:0] result_o,
  output logic        result_valid_o,
  output logic        overflow_o,
  output logic        alarm_o,
  output logic        busy_o
);

  localparam int unsigned SETTLE_CYCLES = 2;
  localparam int unsigned TMR_MAX0 = (GATE_CYCLES > CLR_CYCLES) ? GATE_CYCLES : CLR_CYCLES;
  localparam int unsigned TMR_MAX  = (TMR_MAX0 > SETTLE_CYCLES) ? TMR_MAX0 : SETTLE_CYCLES;
  localparam int unsigned TMR_W    = $clog2(TMR_MAX + 1);
  localparam int unsigned DEB_W    = $clog2(DEB_CYCLES + 1);

  localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] CLR_LAST    = TMR_W'(CLR_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEB_CYCLES - 1);
  localparam logic [13:0]      EVT_SAT     = 14'd10000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_GATE   = 3'd2,
    S_SETTLE = 3'd3,
    S_LATCH  = 3'd4
  } state_t;

  state_t             state_q;
  logic [TMR_W-1:0]   tmr_q;
  logic [13:0]        evt_cnt_q;
  logic               cnt_rst_q, cnt_up_q, result_valid_q, overflow_q, alarm_q, busy_q;
  logic [15:0]        result_q;

  logic               sync1_q, sync2_q, deb_lvl_q, deb_prev_q;
  logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
  logic               deb_lvl_d;
  logic               event_s;
  logic               ovf_s, alarm_s;
  logic [15:0]        res_s;

  // Debounce: count consecutive disagreeing cycles, toggle after DEB_CYCLES.
  always_comb begin
    deb_cnt_d = '0;
    deb_lvl_d = deb_lvl_q;
    if (sync2_q != deb_lvl_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_lvl_d = ~deb_lvl_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end else begin
      deb_cnt_d = '0;
    end
  end

  // Synchroniser, debounce state and previous debounced level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_cnt_q  <= '0;
      deb_lvl_q  <= 1'b0;
      deb_prev_q <= 1'b0;
    end else begin
      sync1_q    <= sensor_i;
      sync2_q    <= sync1_q;
      deb_cnt_q  <= deb_cnt_d;
      deb_lvl_q  <= deb_lvl_d;
      deb_prev_q <= deb_lvl_q;
    end
  end

  assign event_s = deb_lvl_q & ~deb_prev_q;

  // Values captured in LATCH; a saturated event count reports 9999.
  always_comb begin
    ovf_s   = (evt_cnt_q >= EVT_SAT);
    res_s   = ovf_s ? 16'h9999 : count_in_i;
    alarm_s = (thresh_i != 16'h0000) && (res_s >= thresh_i);
  end

  // Sequencer FSM with registered outputs; outputs are set on state entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= S_IDLE;
      tmr_q          <= '0;
      evt_cnt_q      <= 14'd0;
      cnt_rst_q      <= 1'b1;
      cnt_up_q       <= 1'b0;
      result_q       <= 16'h0000;
      result_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
      alarm_q        <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      // An event seen on the last GATE cycle still pulses in the first SETTLE cycle.
      cnt_up_q       <= (state_q == S_GATE) && event_s;
      result_valid_q <= 1'b0;
      if ((state_q == S_GATE) && event_s && (evt_cnt_q != EVT_SAT)) begin
        evt_cnt_q <= evt_cnt_q + 14'd1;
      end else if (state_q == S_CLEAR) begin
        evt_cnt_q <= 14'd0;
      end else begin
        evt_cnt_q <= evt_cnt_q;
      end
      case (state_q)
        S_IDLE: begin
          if (start_i || cont_i) begin
            state_q   <= S_CLEAR;
            tmr_q     <= '0;
            cnt_rst_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (tmr_q == CLR_LAST) begin
            state_q   <= S_GATE;
            tmr_q     <= '0;
            cnt_rst_q <= 1'b0;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        S_GATE: begin
          if (tmr_q == GATE_LAST) begin
            state_q <= S_SETTLE;
            tmr_q   <= '0;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        S_SETTLE: begin
          if (tmr_q == SETTLE_LAST) begin
            state_q <= S_LATCH;
            tmr_q   <= '0;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        S_LATCH: begin
          result_q       <= res_s;
          overflow_q     <= ovf_s;
          alarm_q        <= alarm_s;
          result_valid_q <= 1'b1;
          cnt_rst_q      <= 1'b1;
          tmr_q          <= '0;
          if (cont_i) begin
            state_q <= S_CLEAR;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          tmr_q     <= '0;
          cnt_rst_q <= 1'b1;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign cnt_rst_o      = cnt_rst_q;
  assign cnt_up_o       = cnt_up_q;
  assign result_o       = result_q;
  assign result_valid_o = result_valid_q;
  assign overflow_o     = overflow_q;
  assign alarm_o        = alarm_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_vibration_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vibration_ctrl
// Directed bench for vibration_ctrl. A short-window instance covers counting,
// debounce, gating, alarm, continuous mode and reset; a second instance with a
// long window and minimal debounce covers overflow. Each instance drives a
// behavioural BCD counter that follows cnt_rst/cnt_up.
// -----------------------------------------------------------------------------
module tb_vibration_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, cont, sensor;
  logic [15:0] thresh, count_in;
  logic        cnt_rst, cnt_up, result_valid, overflow, alarm, busy;
  logic [15:0] result;

  logic        start2, cont2, sensor2;
  logic [15:0] thresh2, count_in2;
  logic        cnt_rst2, cnt_up2, result_valid2, overflow2, alarm2, busy2;
  logic [15:0] result2;

  vibration_ctrl #(.GATE_CYCLES(100), .DEB_CYCLES(4), .CLR_CYCLES(2)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .cont_i(cont), .sensor_i(sensor),
    .count_in_i(count_in), .thresh_i(thresh), .cnt_rst_o(cnt_rst), .cnt_up_o(cnt_up),
    .result_o(result), .result_valid_o(result_valid), .overflow_o(overflow),
    .alarm_o(alarm), .busy_o(busy)
  );

  vibration_ctrl #(.GATE_CYCLES(30000), .DEB_CYCLES(1), .CLR_CYCLES(2)) u_ovf (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start2), .cont_i(cont2), .sensor_i(sensor2),
    .count_in_i(count_in2), .thresh_i(thresh2), .cnt_rst_o(cnt_rst2), .cnt_up_o(cnt_up2),
    .result_o(result2), .result_valid_o(result_valid2), .overflow_o(overflow2),
    .alarm_o(alarm2), .busy_o(busy2)
  );

  // Behavioural 4-digit BCD counters (wrap 9999 -> 0000).
  int unsigned ref_cnt, ref_cnt2;

  function automatic logic [15:0] to_bcd(input int unsigned v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  assign count_in  = to_bcd(ref_cnt);
  assign count_in2 = to_bcd(ref_cnt2);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt  <= 0;
      ref_cnt2 <= 0;
    end else begin
      if (cnt_rst) ref_cnt <= 0;
      else if (cnt_up) ref_cnt <= (ref_cnt == 9999) ? 0 : ref_cnt + 1;
      if (cnt_rst2) ref_cnt2 <= 0;
      else if (cnt_up2) ref_cnt2 <= (ref_cnt2 == 9999) ? 0 : ref_cnt2 + 1;
    end
  end

  // Pulse tallies sampled away from the active edge.
  int unsigned up_total = 0, up_total2 = 0, stray = 0;
  always @(negedge clk) begin
    if (cnt_up) up_total++;
    if (cnt_up && (cnt_rst || !busy)) stray++;
    if (cnt_up2) up_total2++;
  end

  int n_checks = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int hi, input int lo);
    sensor = 1'b1; tick(hi);
    sensor = 1'b0; tick(lo);
  endtask

  task automatic wait_gate(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!cnt_rst) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_rv(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (result_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [15:0] thresh;
    int          npulse;
    bit          glitch;
    logic [15:0] exp_result;
    bit          exp_alarm;
  } vec_t;

  // One single-shot window: optional glitches, clean 6/6 pulses, a start
  // request while busy, then result/flag checks.
  task automatic run_window(input vec_t v, input int idx);
    bit ok;
    int unsigned base;
    string tag;
    tag = $sformatf("v%0d", idx);
    thresh = v.thresh;
    start = 1'b1; tick(1); start = 1'b0;
    wait_gate(ok);
    check({tag, "_gate_entry"}, 32'(ok), 32'd1);
    check({tag, "_cnt_zero_at_gate"}, ref_cnt, 32'd0);
    base = up_total;
    if (v.glitch) begin
      pulse(1, 6); pulse(2, 6); pulse(3, 6);
    end
    for (int k = 0; k < v.npulse; k++) pulse(6, 6);
    start = 1'b1; tick(1); start = 1'b0;
    wait_rv(200, ok);
    check({tag, "_rv_seen"}, 32'(ok), 32'd1);
    check({tag, "_result"}, 32'(result), 32'(v.exp_result));
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
    check({tag, "_alarm"}, 32'(alarm), 32'(v.exp_alarm));
    check({tag, "_busy_low_at_rv"}, 32'(busy), 32'd0);
    check({tag, "_cnt_up_pulses"}, up_total - base, 32'(v.npulse));
    tick(1);
    check({tag, "_rv_single"}, 32'(result_valid), 32'd0);
    tick(5);
    check({tag, "_start_busy_ignored"}, 32'(busy), 32'd0);
  endtask

  vec_t vecs [6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    int unsigned base;

    vecs[0] = '{16'h0000, 7, 1'b0, 16'h0007, 1'b0};
    vecs[1] = '{16'h0000, 2, 1'b1, 16'h0002, 1'b0};
    vecs[2] = '{16'h0005, 5, 1'b0, 16'h0005, 1'b1};
    vecs[3] = '{16'h0005, 4, 1'b0, 16'h0004, 1'b0};
    vecs[4] = '{16'h0000, 5, 1'b0, 16'h0005, 1'b0};
    vecs[5] = '{16'h0003, 3, 1'b0, 16'h0003, 1'b1};

    rst_n = 1'b0; start = 1'b0; cont = 1'b0; sensor = 1'b0; thresh = 16'h0000;
    start2 = 1'b0; cont2 = 1'b0; sensor2 = 1'b0; thresh2 = 16'h0000;
    tick(3);
    check("rst_cnt_rst", 32'(cnt_rst), 32'd1);
    check("rst_cnt_up", 32'(cnt_up), 32'd0);
    check("rst_result", 32'(result), 32'h0);
    check("rst_rv", 32'(result_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_alarm", 32'(alarm), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick(2);

    for (int i = 0; i < 6; i++) run_window(vecs[i], i);

    // Events in IDLE and in CLEAR are dropped; one in-window event counts.
    thresh = 16'h0000;
    base = up_total;
    pulse(6, 6);
    sensor = 1'b1; tick(5);
    start = 1'b1; tick(1); start = 1'b0;
    wait_gate(ok);
    check("clr_gate_entry", 32'(ok), 32'd1);
    check("clr_cnt_zero_at_gate", ref_cnt, 32'd0);
    check("clr_no_up_before_gate", up_total - base, 32'd0);
    tick(8); sensor = 1'b0; tick(8);
    pulse(6, 6);
    wait_rv(200, ok);
    check("clr_rv_seen", 32'(ok), 32'd1);
    check("clr_result", 32'(result), 32'h0001);
    check("clr_up_pulses", up_total - base, 32'd1);
    pulse(6, 6); tick(8);
    check("idle_event_dropped", up_total - base, 32'd1);

    // Event on the final GATE cycle pulses in the first SETTLE cycle.
    start = 1'b1; tick(1); start = 1'b0;
    wait_gate(ok);
    check("last_gate_entry", 32'(ok), 32'd1);
    base = up_total;
    tick(93); sensor = 1'b1; tick(7);
    check("last_cycle_up_in_settle", 32'(cnt_up), 32'd1);
    tick(1); sensor = 1'b0;
    wait_rv(50, ok);
    check("last_cycle_rv_seen", 32'(ok), 32'd1);
    check("last_cycle_result", 32'(result), 32'h0001);
    check("last_cycle_pulses", up_total - base, 32'd1);
    tick(10);

    // Event one cycle after the window is dropped.
    start = 1'b1; tick(1); start = 1'b0;
    wait_gate(ok);
    check("late_gate_entry", 32'(ok), 32'd1);
    base = up_total;
    tick(94); sensor = 1'b1; tick(6);
    check("late_no_up_a", 32'(cnt_up), 32'd0);
    tick(1);
    check("late_no_up_b", 32'(cnt_up), 32'd0);
    sensor = 1'b0;
    wait_rv(50, ok);
    check("late_rv_seen", 32'(ok), 32'd1);
    check("late_result", 32'(result), 32'h0000);
    check("late_pulses", up_total - base, 32'd0);
    tick(10);

    // Continuous mode: two windows (3 then 4 events), cont dropped in the second.
    thresh = 16'h0002;
    cont = 1'b1; start = 1'b1; tick(1); start = 1'b0;
    wait_gate(ok);
    check("cont1_gate_entry", 32'(ok), 32'd1);
    for (int k = 0; k < 3; k++) pulse(6, 6);
    wait_rv(200, ok);
    check("cont1_rv_seen", 32'(ok), 32'd1);
    check("cont1_result", 32'(result), 32'h0003);
    check("cont1_alarm", 32'(alarm), 32'd1);
    check("cont1_busy_stays", 32'(busy), 32'd1);
    tick(1);
    wait_gate(ok);
    check("cont2_gate_entry", 32'(ok), 32'd1);
    for (int k = 0; k < 4; k++) pulse(6, 6);
    cont = 1'b0;
    wait_rv(200, ok);
    check("cont2_rv_seen", 32'(ok), 32'd1);
    check("cont2_result", 32'(result), 32'h0004);
    check("cont2_busy_low", 32'(busy), 32'd0);
    tick(5);
    check("cont_back_idle", 32'(busy), 32'd0);

    // Reset mid-window returns everything to reset values at once.
    thresh = 16'h0000;
    start = 1'b1; tick(1); start = 1'b0;
    wait_gate(ok);
    check("mid_rst_gate_entry", 32'(ok), 32'd1);
    pulse(6, 6); pulse(6, 6);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cnt_rst", 32'(cnt_rst), 32'd1);
    check("mid_rst_cnt_up", 32'(cnt_up), 32'd0);
    check("mid_rst_result", 32'(result), 32'h0);
    check("mid_rst_rv", 32'(result_valid), 32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    check("mid_rst_alarm", 32'(alarm), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    tick(2); rst_n = 1'b1; tick(2);
    check("post_rst_idle", 32'(busy), 32'd0);
    run_window('{16'h0000, 2, 1'b0, 16'h0002, 1'b0}, 9);

    check("no_cnt_up_outside_gate", stray, 32'd0);

    // Overflow instance: 10001 events saturate the event count.
    thresh2 = 16'h5000;
    start2 = 1'b1; tick(1); start2 = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!cnt_rst2) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("ovf_gate_entry", 32'(ok), 32'd1);
    base = up_total2;
    for (int k = 0; k < 10001; k++) begin
      sensor2 = 1'b1; tick(1);
      sensor2 = 1'b0; tick(1);
    end
    ok = 1'b0;
    for (int i = 0; i < 40000; i++) begin
      if (result_valid2) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("ovf_rv_seen", 32'(ok), 32'd1);
    check("ovf_result", 32'(result2), 32'h9999);
    check("ovf_flag", 32'(overflow2), 32'd1);
    check("ovf_alarm", 32'(alarm2), 32'd1);
    check("ovf_up_pulses", up_total2 - base, 32'd10001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
